bus_dma_master: RTL

- Bus initiator that copies a block of bytes from a source address to a destination address on the shared 8-bit BUS_ADDR/BUS_DATA/BUS_WE bus.
- Talks to memory-mapped responders such as the data RAM, using their timing: address registered at a clock edge, read data driven one cycle later, write committed at the edge while BUS_WE is high.
- Shares the bus with the processor through a REQ/GNT handshake with the system arbiter.

---
 rtl/bus_dma_master.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bus_dma_master.sv
// Byte-copy bus initiator: reads src, writes dst, one byte per 4 bus cycles,
// holding the arbiter request for the whole job.
module bus_dma_master #(
  parameter int                   AddrWidth = 8,
  parameter logic [AddrWidth-1:0] IdleAddr  = 8'hFF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  inout  wire  [7:0]           BUS_DATA,
  output logic [AddrWidth-1:0] BUS_ADDR,
  output logic                 BUS_WE,
  output logic                 BUS_REQ,
  input  logic                 BUS_GNT,
  input  logic                 START,
  input  logic [AddrWidth-1:0] SRC_ADDR,
  input  logic [AddrWidth-1:0] DST_ADDR,
  input  logic [7:0]           LENGTH,
  output logic                 BUSY,
  output logic                 DONE
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD1, S_RD2, S_TURN, S_WR, S_FIN
  } state_e;

  localparam logic [AddrWidth-1:0] AddrOne = 1;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] src_q, src_d, dst_q, dst_d;
  logic [7:0]           cnt_q, cnt_d, buf_q, buf_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d, req_q, req_d, busy_q, busy_d, done_q, done_d;
  logic                 zero_done;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    zero_done = 1'b0;
    case (state_q)
      S_IDLE: if (START) begin
        if (LENGTH != 8'd0) begin
          src_d   = SRC_ADDR;
          dst_d   = DST_ADDR;
          cnt_d   = LENGTH;
          state_d = S_REQ;
        end else begin
          zero_done = 1'b1;
        end
      end
      S_REQ:  if (BUS_GNT) state_d = S_RD1;
      S_RD1:  state_d = S_RD2;
      S_RD2: begin
        buf_d   = BUS_DATA;
        state_d = S_TURN;
      end
      S_TURN: state_d = S_WR;
      S_WR: begin
        src_d = src_q + AddrOne;
        dst_d = dst_q + AddrOne;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1)  state_d = S_FIN;
        else if (BUS_GNT)   state_d = S_RD1;
        else                state_d = S_REQ;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    addr_d = IdleAddr;
    we_d   = 1'b0;
    req_d  = 1'b0;
    busy_d = 1'b0;
    done_d = zero_done || (state_d == S_FIN);
    case (state_d)
      S_REQ, S_TURN: begin
        req_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_RD1, S_RD2: begin
        addr_d = src_d;
        req_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_WR: begin
        addr_d = dst_d;
        we_d   = 1'b1;
        req_d  = 1'b1;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= IdleAddr;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Data is driven only while the registered write strobe is high, so reset
  // releases the bus asynchronously along with BUS_WE.
  assign BUS_DATA = we_q ? buf_q : {8{1'bz}};
  assign BUS_ADDR = addr_q;
  assign BUS_WE   = we_q;
  assign BUS_REQ  = req_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule
